// File: rtl/bpsk_pkg.sv
// ============================================================================
// bpsk_pkg : shared types and constants for the BPSK transmit frame path
// Rev 1.0
// ============================================================================
`default_nettype none

package bpsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_GUARD    = 2'd3
    } state_t;

    localparam logic        PREAMBLE_FIRST_BIT = 1'b1;
    localparam logic [31:0] PHASE_STEP_DEF     = 32'd85899346;
    localparam int          SYM_CYCLES_DEF     = 50;

    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    localparam int SYM_CNT_W = cnt_width(SYM_CYCLES_DEF);

endpackage

`default_nettype wire

// File: rtl/bpsk_sym_timer.sv
// ============================================================================
// bpsk_sym_timer : free-running symbol counter with a last-clock strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module bpsk_sym_timer
    import bpsk_pkg::*;
#(
    parameter int SYM_CYCLES = SYM_CYCLES_DEF,
    parameter int CNT_W      = cnt_width(SYM_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_i,
    input  logic             clear_i,
    output logic             sym_strobe_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(SYM_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = (count_q == C_LAST) ? '0 : count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign sym_strobe_o = enable_i && !clear_i && (count_q == C_LAST);
    assign count_o      = count_q;

endmodule

`default_nettype wire

// File: rtl/bpsk_tx_frame_ctrl.sv
// ============================================================================
// bpsk_tx_frame_ctrl : frames payload bytes into preamble/data/guard symbols
// Rev 1.0
// ============================================================================
`default_nettype none

module bpsk_tx_frame_ctrl
    import bpsk_pkg::*;
#(
    parameter int          SYM_CYCLES    = SYM_CYCLES_DEF,
    parameter int          PREAMBLE_BITS = 16,
    parameter int          GUARD_SYMS    = 4,
    parameter logic [31:0] PHASE_STEP    = PHASE_STEP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic        bit_out,
    output logic        tx_en,
    output logic [31:0] phase_step,
    output logic        sym_strobe,
    output logic        busy,
    output logic        underrun
);

    localparam int C_CNT_W   = cnt_width(SYM_CYCLES);
    localparam int C_IDX_MAX = (PREAMBLE_BITS > GUARD_SYMS) ? PREAMBLE_BITS : GUARD_SYMS;
    localparam int C_IDX_W   = $clog2(C_IDX_MAX + 1);

    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(SYM_CYCLES - 1);
    localparam logic [C_IDX_W-1:0] C_PRE_LAST = C_IDX_W'(PREAMBLE_BITS - 1);
    localparam logic [C_IDX_W-1:0] C_GRD_LAST = C_IDX_W'(GUARD_SYMS - 1);

    state_t              state_q;
    logic                bit_out_q;
    logic                tx_en_q;
    logic                underrun_q;
    logic                last_q;
    logic [C_IDX_W-1:0]  sym_idx_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          shreg_q;
    logic [31:0]         phase_q;

    logic                w_idle;
    logic                w_strobe;
    logic [C_CNT_W-1:0]  w_count;
    logic                w_boundary;
    logic                w_xfer;

    assign w_idle = (state_q == ST_IDLE);

    bpsk_sym_timer #(
        .SYM_CYCLES (SYM_CYCLES),
        .CNT_W      (C_CNT_W)
    ) u_sym_timer (
        .clk          (clk),
        .rst          (rst),
        .enable_i     (!w_idle),
        .clear_i      (w_idle),
        .sym_strobe_o (w_strobe),
        .count_o      (w_count)
    );

    // Only the last clock of the final preamble symbol or of bit 7 of a non-final byte accepts data.
    assign w_boundary = ((state_q == ST_PREAMBLE) && (sym_idx_q == C_PRE_LAST)) ||
                        ((state_q == ST_DATA) && (bit_idx_q == 3'd7) && !last_q);
    assign s_ready    = w_boundary && (w_count == C_CNT_LAST);
    assign w_xfer     = s_ready && s_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_out_q  <= 1'b0;
            tx_en_q    <= 1'b0;
            underrun_q <= 1'b0;
            last_q     <= 1'b0;
            sym_idx_q  <= '0;
            bit_idx_q  <= 3'd0;
            shreg_q    <= 8'd0;
            phase_q    <= PHASE_STEP;
        end else if (w_xfer) begin
            // Load happens at a symbol boundary; first data bit goes out immediately.
            state_q   <= ST_DATA;
            bit_out_q <= s_data[0];
            shreg_q   <= {1'b0, s_data[7:1]};
            last_q    <= s_last;
            bit_idx_q <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_valid) begin
                        state_q    <= ST_PREAMBLE;
                        bit_out_q  <= PREAMBLE_FIRST_BIT;
                        tx_en_q    <= 1'b1;
                        underrun_q <= 1'b0;
                        sym_idx_q  <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    if (w_strobe) begin
                        if (sym_idx_q == C_PRE_LAST) begin
                            state_q    <= ST_GUARD;
                            bit_out_q  <= 1'b0;
                            underrun_q <= 1'b1;
                            sym_idx_q  <= '0;
                        end else begin
                            bit_out_q <= ~bit_out_q;
                            sym_idx_q <= sym_idx_q + C_IDX_W'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (w_strobe) begin
                        if (bit_idx_q == 3'd7) begin
                            state_q    <= ST_GUARD;
                            bit_out_q  <= 1'b0;
                            underrun_q <= underrun_q | ~last_q;
                            sym_idx_q  <= '0;
                        end else begin
                            bit_out_q <= shreg_q[0];
                            shreg_q   <= {1'b0, shreg_q[7:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                ST_GUARD: begin
                    if (w_strobe) begin
                        if (sym_idx_q == C_GRD_LAST) begin
                            state_q   <= ST_IDLE;
                            tx_en_q   <= 1'b0;
                            bit_out_q <= 1'b0;
                            sym_idx_q <= '0;
                        end else begin
                            sym_idx_q <= sym_idx_q + C_IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bit_out    = bit_out_q;
    assign tx_en      = tx_en_q;
    assign busy       = !w_idle;
    assign underrun   = underrun_q;
    assign phase_step = phase_q;
    assign sym_strobe = w_strobe;

endmodule

`default_nettype wire

// File: tb/tb_bpsk_tx_frame_ctrl.sv
// ============================================================================
// tb_bpsk_tx_frame_ctrl : symbol-list reference model bench for the frame controller
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bpsk_tx_frame_ctrl;

    localparam int          SYM   = 50;
    localparam int          PRE   = 16;
    localparam int          GRD   = 4;
    localparam logic [31:0] PSTEP = 32'd85899346;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_data = 8'd0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        bit_out;
    logic        tx_en;
    logic [31:0] phase_step;
    logic        sym_strobe;
    logic        busy;
    logic        underrun;

    int          n_chk = 0;
    int          n_pass = 0;
    int          strobe_cnt = 0;
    logic [7:0]  frame_q[$];

    bpsk_tx_frame_ctrl u_dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .bit_out    (bit_out),
        .tx_en      (tx_en),
        .phase_step (phase_step),
        .sym_strobe (sym_strobe),
        .busy       (busy),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".bit_out"},    32'(bit_out),    32'd0);
        check({tag, ".tx_en"},      32'(tx_en),      32'd0);
        check({tag, ".s_ready"},    32'(s_ready),    32'd0);
        check({tag, ".sym_strobe"}, 32'(sym_strobe), 32'd0);
        check({tag, ".busy"},       32'(busy),       32'd0);
        check({tag, ".underrun"},   32'(underrun),   32'd0);
        check({tag, ".phase_step"}, phase_step,      PSTEP);
    endtask

    // Model: a frame is a list of symbols (value, accepts-data flag); each lasts SYM clocks.
    task automatic run_frame(input int n, input bit with_last, input int abort_at);
        bit   exp_bit[$];
        bit   exp_rdy[$];
        int   under_sym;
        int   total;
        int   src;
        int   sym;
        bit   end_sym;
        bit   cur_rdy;
        bit   exp_under;
        logic [7:0] b;

        for (int i = 0; i < PRE; i++) begin
            exp_bit.push_back((i % 2) == 0);
            exp_rdy.push_back(i == PRE - 1);
        end
        for (int j = 0; j < n; j++) begin
            b = frame_q[j];
            for (int k = 0; k < 8; k++) begin
                exp_bit.push_back(b[k]);
                exp_rdy.push_back((k == 7) && ((j < n - 1) || !with_last));
            end
        end
        for (int i = 0; i < GRD; i++) begin
            exp_bit.push_back(1'b0);
            exp_rdy.push_back(1'b0);
        end
        under_sym  = with_last ? -1 : (PRE + 8 * n - 1);
        total      = exp_bit.size() * SYM;
        src        = 0;
        strobe_cnt = 0;

        s_valid = 1'b1;
        s_data  = (n > 0) ? frame_q[0] : 8'($urandom);
        s_last  = with_last && (n == 1);

        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            sym       = (k - 1) / SYM;
            end_sym   = ((k - 1) % SYM) == (SYM - 1);
            cur_rdy   = end_sym && exp_rdy[sym];
            exp_under = (under_sym >= 0) && (k > (under_sym + 1) * SYM);
            check("bit_out",    32'(bit_out),    32'(exp_bit[sym]));
            check("tx_en",      32'(tx_en),      32'd1);
            check("busy",       32'(busy),       32'd1);
            check("sym_strobe", 32'(sym_strobe), 32'(end_sym));
            check("s_ready",    32'(s_ready),    32'(cur_rdy));
            check("underrun",   32'(underrun),   32'(exp_under));
            if (sym_strobe) strobe_cnt++;
            if (k == abort_at) begin
                rst     = 1'b1;
                s_valid = 1'b0;
                @(negedge clk);
                check_reset("abort");
                rst = 1'b0;
                return;
            end
            if (src < n) begin
                s_valid = 1'b1;
                s_data  = frame_q[src];
                s_last  = with_last && (src == n - 1);
            end else begin
                s_valid = cur_rdy ? 1'b0 : 1'($urandom);
                s_data  = 8'($urandom);
                s_last  = 1'($urandom);
            end
            if (s_valid && cur_rdy) src++;
        end

        @(negedge clk);
        check("end.busy",       32'(busy),     32'd0);
        check("end.tx_en",      32'(tx_en),    32'd0);
        check("end.bit_out",    32'(bit_out),  32'd0);
        check("end.s_ready",    32'(s_ready),  32'd0);
        check("end.underrun",   32'(underrun), 32'(under_sym >= 0));
        check("end.phase_step", phase_step,    PSTEP);
        s_valid = 1'b0;
    endtask

    initial begin
        int  n;
        bit  wl;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            s_valid = 1'b0;
            s_data  = 8'($urandom);
            s_last  = 1'($urandom);
            @(negedge clk);
            check("idle.tx_en",      32'(tx_en),      32'd0);
            check("idle.sym_strobe", 32'(sym_strobe), 32'd0);
            check("idle.busy",       32'(busy),       32'd0);
            check("idle.s_ready",    32'(s_ready),    32'd0);
        end

        frame_q = '{8'hA5};
        run_frame(1, 1'b1, 0);
        check("strobe_count", 32'(strobe_cnt), 32'd28);

        frame_q = '{8'h01, 8'hFF};
        run_frame(2, 1'b1, 0);

        frame_q = '{8'h3C};
        run_frame(1, 1'b0, 0);

        frame_q.delete();
        run_frame(0, 1'b0, 0);

        frame_q = '{8'h3C, 8'h55};
        run_frame(2, 1'b1, 900);
        run_frame(2, 1'b1, 0);

        repeat (8) begin
            wl = 1'($urandom);
            n  = wl ? $urandom_range(1, 3) : $urandom_range(0, 3);
            frame_q.delete();
            for (int j = 0; j < n; j++) frame_q.push_back(8'($urandom));
            run_frame(n, wl, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bpsk_tx_frame_ctrl.md
Name: bpsk_tx_frame_ctrl

Overview:
Frame-level controller that sequences the bit_in input of the BPSK transmitter.
- Accepts payload bytes over a valid/ready stream.
- Prepends an alternating preamble and appends a guard interval.
- Holds each symbol for a fixed number of clocks.
- Drives a constant carrier phase_step configuration to the transmitter.
- Sits between the packet source and bpsk_tx; tx_en gates the transmitter output downstream.

Parameters:
SYM_CYCLES, 50, clocks per symbol (1 µs at 50 MHz); must be >= 2
PREAMBLE_BITS, 16, preamble length in symbols; must be >= 1
GUARD_SYMS, 4, trailing guard symbols (bit 0); must be >= 1
PHASE_STEP, 32'd85899346, carrier NCO step driven to the transmitter (about 1 MHz at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
s_data  in  8  payload byte
s_valid  in  1  byte available / frame request
s_last  in  1  qualifies s_data as the final byte of the frame
s_ready  out  1  byte accepted when s_valid && s_ready
bit_out  out  1  symbol to bpsk_tx bit_in
tx_en  out  1  transmitter output enable
phase_step  out  32  carrier step to bpsk_tx
sym_strobe  out  1  pulse on the last clock of each symbol
busy  out  1  state != IDLE
underrun  out  1  sticky: stream starved mid-frame

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high; it takes effect at the next rising edge.
- Reset values: state=IDLE, bit_out=0, tx_en=0, s_ready=0, sym_strobe=0, busy=0, underrun=0, phase_step=PHASE_STEP, symbol counter=0, bit index=0.
- Symbol timer:
  - Counter runs 0..SYM_CYCLES-1 while busy, then wraps.
  - sym_strobe=1 when the counter equals SYM_CYCLES-1.
  - bit_out, tx_en and state update only on the edge following sym_strobe, except for the IDLE exit.
  - Counter is held at 0 in IDLE.
- IDLE:
  - tx_en=0, bit_out=0, s_ready=0.
  - s_valid=1 sampled at edge t moves the FSM to PREAMBLE; bit_out=1 and tx_en=1 are visible from cycle t+1.
  - underrun is cleared on this transition.
  - The first byte is not consumed here.
- PREAMBLE:
  - PREAMBLE_BITS symbols alternating 1,0,1,... starting with 1.
  - s_ready=1 only during the final clock of the final preamble symbol.
  - Transfer on that clock: load the shift register, latch s_last, go to DATA.
  - No transfer (s_valid=0): set underrun, go to GUARD.
- DATA:
  - 8 symbols per byte, LSB first.
  - During the final clock of bit 7:
    - Latched last=1: s_ready=0, go to GUARD.
    - Otherwise s_ready=1. On transfer, load the next byte and stay in DATA with no gap symbol. With no transfer, set underrun and go to GUARD.
- GUARD:
  - GUARD_SYMS symbols with bit_out=0 and tx_en=1.
  - On the final sym_strobe, go to IDLE; tx_en=0 and busy=0 from the next cycle.
  - s_valid asserted in the same cycle as the return to IDLE is not sampled until the following edge.
- s_ready is never asserted outside the single boundary clock. The source must present data before or on that clock.
- s_data and s_last are ignored when no transfer occurs.
- rst mid-frame aborts immediately:
  - all registers return to reset values at the next edge;
  - the held byte is discarded;
  - no guard is sent.
- phase_step is a registered constant and never changes after reset.

Decomposition:
- Package bpsk_pkg:
  - FSM state enum (IDLE, PREAMBLE, DATA, GUARD);
  - PREAMBLE_FIRST_BIT=1;
  - the PHASE_STEP default constant;
  - counter width derived from SYM_CYCLES via $clog2.
- One sub-module, bpsk_sym_timer:
  - inputs: enable, clear;
  - outputs: sym_strobe, count;
  - reused by the future receiver bit-slicer.

Test Plan:
All timing below uses the defaults SYM_CYCLES=50, PREAMBLE_BITS=16, GUARD_SYMS=4.
- Single byte: s_valid=1, s_last=1, s_data=0xA5 sampled at edge t.
  - Preamble 1010... on cycles t+1..t+800; s_ready=1 only on t+800.
  - bits 1,0,1,0,0,1,0,1 on t+801..t+1200.
  - bit_out=0 with tx_en=1 on t+1201..t+1400.
  - busy=0 and tx_en=0 at t+1401; underrun=0.
- Back-to-back frame of 0x01, 0xFF (last): second transfer on t+1200, data continuous on t+801..t+1600, guard ends at t+1800.
- Underrun: first byte 0x3C without s_last, then s_valid=0 at the t+1200 boundary. Expect underrun=1 from t+1201, guard of 200 cycles, IDLE; underrun clears on the next frame start.
- Preamble underrun: s_valid pulsed for 1 cycle in IDLE, then low. Expect 16 preamble symbols, underrun set, no DATA symbols, guard, then IDLE.
- Reset mid-DATA: rst=1 at t+900. Expect all outputs at reset values from t+901 (phase_step=85899346); s_valid=1 after release restarts a full preamble.
- Idle hold and strobe count: s_valid=0 for 1000 cycles gives tx_en=0 and sym_strobe=0 throughout; during the single-byte frame, count exactly 28 sym_strobe pulses.
